// File: rtl/nebula_pkg.sv
// -----------------------------------------------------------------------------
// nebula package
// Shared types for the instruction-fetch front end.
//   word_t        : 32-bit machine word / address
//   fetch_entry_t : one instruction-queue entry {pc, instr, fault}
//   fetch_state_e : fetch sequencer state (Run issues requests, Halt waits for
//                   a redirect after a fault entry)
//   InstrBytes    : PC increment per fetched instruction word
// -----------------------------------------------------------------------------
package nebula;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
    logic  fault;
  } fetch_entry_t;

  typedef enum logic {
    Run  = 1'b0,
    Halt = 1'b1
  } fetch_state_e;

  localparam word_t InstrBytes = 32'd4;

endpackage : nebula

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Synchronous FIFO of fetch_entry_t with flush. The head entry is read
// combinationally. A push into a full queue is accepted when a pop happens in
// the same cycle (occupancy unchanged). Flush wins over push and pop.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   flush_i        : discard all entries this cycle
//   push_i/entry_i : enqueue request and data
//   pop_i          : dequeue head (ignored when empty)
//   head_o         : entry at the head of the queue
//   full_o/empty_o : occupancy flags
//   count_o        : number of valid entries (0..Depth)
// -----------------------------------------------------------------------------
module fetch_queue
  import nebula::*;
#(
  parameter int Depth = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fetch_entry_t           entry_i,
  input  logic                   pop_i,
  output fetch_entry_t           head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int AddrW = $clog2(Depth);
  localparam int CntW  = AddrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(Depth);

  fetch_entry_t     r_mem [Depth];
  logic [AddrW-1:0] r_wr_ptr;
  logic [AddrW-1:0] r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  // NOTE: every signal driven here gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    w_pop   = pop_i && (r_count != '0);
    w_push  = push_i && ((r_count != DepthC) || w_pop);
    full_o  = (r_count == DepthC);
    empty_o = (r_count == '0);
    count_o = r_count;
    head_o  = r_mem[r_rd_ptr];
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are meaningful, and leaving the array out of reset
  // lets it map onto plain registers or RAM.
  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) begin
      r_mem[r_wr_ptr] <= entry_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Depth is a power of two, so the pointers wrap naturally.
      if (w_push) r_wr_ptr <= r_wr_ptr + AddrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AddrW'(1);
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

endmodule : fetch_queue

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch sequencer. Owns the PC, issues in-order word requests to
// instruction memory, buffers responses in fetch_queue and presents the head
// entry {pc, instr, fault} to decode over valid/ready. A redirect flushes the
// queue and discards every response still in flight.
// Optional build macro: NEBULA_FETCH_STATS_EN adds saturating counters
// fetched_o (entries popped by decode) and stall_o (cycles decode was ready
// but nothing was valid).
// Ports:
//   clk_i, rst_n_i          : clock, asynchronous active-low reset
//   imem_req_valid_o/ready_i/addr_o : word fetch request channel
//   imem_rsp_valid_i/data_i/err_i   : in-order response channel, never stalled
//   redirect_valid_i/pc_i   : flush and restart fetching at redirect_pc_i
//   decode_valid_o/ready_i  : handshake towards decode
//   decode_pc_o/instr_o/fault_o : head entry (all zero while not valid)
//   fetched_o, stall_o      : statistics (NEBULA_FETCH_STATS_EN only)
// -----------------------------------------------------------------------------
module fetch_ctrl
  import nebula::*;
#(
  parameter word_t ResetPc    = 32'h0000_0000,
  parameter int    QueueDepth = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output word_t       imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  word_t       imem_rsp_data_i,
  input  logic        imem_rsp_err_i,
  input  logic        redirect_valid_i,
  input  word_t       redirect_pc_i,
  output logic        decode_valid_o,
  input  logic        decode_ready_i,
  output word_t       decode_pc_o,
  output word_t       decode_instr_o,
  output logic        decode_fault_o
`ifdef NEBULA_FETCH_STATS_EN
  ,
  output logic [31:0] fetched_o,
  output logic [31:0] stall_o
`endif
);

  localparam int CntW = $clog2(QueueDepth) + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(QueueDepth);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  word_t           r_fetch_pc;
  word_t           r_rsp_pc;
  logic [CntW-1:0] r_outstanding;
  logic [CntW-1:0] r_drop;
  logic            r_active;
  logic            r_mis_pending;

  logic [CntW-1:0] w_count;
  logic [CntW:0]   w_inflight;
  logic            w_full;
  logic            w_empty;
  logic            w_req_fire;
  logic            w_rsp_take;
  logic            w_push_mis;
  logic            w_push;
  logic            w_pop;
  logic            w_misaligned;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;

  fetch_queue #(
    .Depth (QueueDepth)
  ) u_queue (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (redirect_valid_i),
    .push_i  (w_push),
    .entry_i (w_push_entry),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  always_comb begin
    w_misaligned = (redirect_pc_i[1:0] != 2'b00);

    // Credit check: every in-flight request already owns a queue slot, so
    // responses can never find the queue full.
    w_inflight       = {1'b0, r_outstanding} + {1'b0, w_count};
    imem_req_valid_o = r_active && (r_state == Run) && !redirect_valid_i &&
                       (w_inflight < {1'b0, DepthC});
    imem_req_addr_o  = r_fetch_pc;
    w_req_fire       = imem_req_valid_o && imem_req_ready_i;

    // Responses are enqueued only when they belong to the current stream:
    // stale ones (r_drop) and anything after a fault (Halt) are discarded.
    w_rsp_take = imem_rsp_valid_i && !redirect_valid_i &&
                 (r_drop == '0) && (r_state == Run);
    w_push_mis = r_mis_pending && !w_full && !redirect_valid_i;
    w_push     = w_rsp_take || w_push_mis;

    w_push_entry.pc    = r_rsp_pc;
    w_push_entry.fault = w_push_mis || imem_rsp_err_i;
    w_push_entry.instr = w_push_entry.fault ? '0 : imem_rsp_data_i;

    decode_valid_o = !w_empty;
    w_pop          = decode_valid_o && decode_ready_i;
    decode_pc_o    = decode_valid_o ? w_head.pc    : '0;
    decode_instr_o = decode_valid_o ? w_head.instr : '0;
    decode_fault_o = decode_valid_o && w_head.fault;

    w_state_nxt = r_state;
    if (redirect_valid_i) begin
      w_state_nxt = w_misaligned ? Halt : Run;
    end else if (w_rsp_take && imem_rsp_err_i) begin
      w_state_nxt = Halt;
    end
  end

  // r_active keeps the request channel quiet for the first cycle out of reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= Run;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_active <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_fetch_pc    <= ResetPc;
      r_rsp_pc      <= ResetPc;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_mis_pending <= 1'b0;
    end else if (redirect_valid_i) begin
      // Everything still in flight (less a response landing now, which is
      // discarded) belongs to the old stream and must be dropped on return.
      r_fetch_pc    <= redirect_pc_i;
      r_rsp_pc      <= redirect_pc_i;
      r_outstanding <= r_outstanding - CntW'(imem_rsp_valid_i);
      r_drop        <= r_outstanding - CntW'(imem_rsp_valid_i);
      r_mis_pending <= w_misaligned;
    end else begin
      if (w_req_fire) r_fetch_pc <= r_fetch_pc + InstrBytes;
      if (w_push)     r_rsp_pc   <= r_rsp_pc + InstrBytes;
      r_outstanding <= r_outstanding + CntW'(w_req_fire) - CntW'(imem_rsp_valid_i);
      if (imem_rsp_valid_i && (r_drop != '0)) r_drop <= r_drop - CntW'(1);
      if (w_push_mis) r_mis_pending <= 1'b0;
    end
  end

  a_outstanding_bound : assert property (
    @(posedge clk_i) disable iff (!rst_n_i) r_outstanding <= DepthC
  );

`ifdef NEBULA_FETCH_STATS_EN
  logic [31:0] r_fetched;
  logic [31:0] r_stall;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_fetched <= '0;
      r_stall   <= '0;
    end else begin
      if (w_pop && (r_fetched != '1)) r_fetched <= r_fetched + 32'd1;
      if (decode_ready_i && !decode_valid_o && (r_stall != '1)) r_stall <= r_stall + 32'd1;
    end
  end

  assign fetched_o = r_fetched;
  assign stall_o   = r_stall;
`endif

endmodule : fetch_ctrl
